// File: rtl/pmu_rstseq_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pmu_rstseq_pkg
// Purpose  : Shared types, cause codes and sizing helper for the reset sequencer
// Revision : 1.0 - initial release
// ============================================================================
package pmu_rstseq_pkg;

    typedef enum logic [1:0] {
        S_HOLD = 2'd0,
        S_REL  = 2'd1,
        S_RUN  = 2'd2
    } state_e;

    localparam logic [1:0] CAUSE_POR = 2'b00;
    localparam logic [1:0] CAUSE_SYS = 2'b01;
    localparam logic [1:0] CAUSE_DOM = 2'b10;

    // Smallest counter width able to represent max(HOLD, STAGGER)
    function automatic int min_cnt_w(input int hold, input int stagger);
        int m;
        m = (hold > stagger) ? hold : stagger;
        return $clog2(m + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/pmu_rstseq_if.sv
`default_nettype none
// ============================================================================
// Module   : pmu_rstseq_if
// Purpose  : Request/status bundle between the PMU and the reset sequencer
// Revision : 1.0 - initial release
// ============================================================================
interface pmu_rstseq_if #(
    parameter int N_DOM = 4
);
    logic             test_en;
    logic             test_rst_n;
    logic             sys_rst_req;
    logic [N_DOM-1:0] dom_rst_req;
    logic [N_DOM-1:0] sleep_hold;
    logic             cause_clr;
    logic [N_DOM-1:0] rst_n_out;
    logic             seq_busy;
    logic [1:0]       rst_cause;

    modport master (
        output test_en, test_rst_n, sys_rst_req, dom_rst_req, sleep_hold, cause_clr,
        input  rst_n_out, seq_busy, rst_cause
    );

    modport slave (
        input  test_en, test_rst_n, sys_rst_req, dom_rst_req, sleep_hold, cause_clr,
        output rst_n_out, seq_busy, rst_cause
    );
endinterface
`default_nettype wire

// File: rtl/pmu_rst_sync.sv
`default_nettype none
// ============================================================================
// Module   : pmu_rst_sync
// Purpose  : Multi-stage request synchroniser with single-cycle rising-edge pulse
// Revision : 1.0 - initial release
// ============================================================================
module pmu_rst_sync
    import pmu_rstseq_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk_16m,
    input  logic rst_16m,
    input  logic async_i,
    output logic trig_o
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   dly_q;

    always_ff @(posedge clk_16m) begin
        if (rst_16m) begin
            sync_q <= '0;
            dly_q  <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], async_i};
            dly_q  <= sync_q[SYNC_STAGES-1];
        end
    end

    assign trig_o = sync_q[SYNC_STAGES-1] & ~dly_q;

endmodule
`default_nettype wire

// File: rtl/pmu_rstseq.sv
`default_nettype none
// ============================================================================
// Module   : pmu_rstseq
// Purpose  : Multi-domain reset sequencer with staggered release, sleep holds,
//            test bypass. Define PMU_RSTSEQ_CAUSE_EN to build the cause register.
// Revision : 1.0 - initial release
// ============================================================================
module pmu_rstseq
    import pmu_rstseq_pkg::*;
#(
    parameter int N_DOM       = 4,
    parameter int CNT_W       = 5,
    parameter int HOLD        = 15,
    parameter int STAGGER     = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic               clk_16m,
    input  logic               rst_16m,
    pmu_rstseq_if.slave        bus
);

    localparam int             IDX_W       = $clog2(N_DOM + 1);
    localparam logic [CNT_W-1:0] C_HOLD_LAST = CNT_W'(HOLD - 1);
    localparam logic [CNT_W-1:0] C_STAG_LAST = CNT_W'(STAGGER - 1);
    localparam logic [IDX_W-1:0] C_IDX_LAST  = IDX_W'(N_DOM - 1);

    if (CNT_W < min_cnt_w(HOLD, STAGGER)) begin : g_cnt_w_chk
        $error("pmu_rstseq: CNT_W too narrow for HOLD/STAGGER");
    end

    logic             sys_trig;
    logic [N_DOM-1:0] dom_trig;
    logic [N_DOM-1:0] dom_low;
    logic [N_DOM-1:0] rst_n_d;
    logic             busy_d;

    state_e           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [IDX_W-1:0] idx_q;
    logic [N_DOM-1:0] rel_q;
    logic [CNT_W-1:0] dcnt_q [N_DOM];
    logic [N_DOM-1:0] rst_n_q;
    logic             busy_q;

    pmu_rst_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sys_sync (
        .clk_16m (clk_16m),
        .rst_16m (rst_16m),
        .async_i (bus.sys_rst_req),
        .trig_o  (sys_trig)
    );

    for (genvar gi = 0; gi < N_DOM; gi++) begin : g_dom_sync
        pmu_rst_sync #(.SYNC_STAGES(SYNC_STAGES)) u_dom_sync (
            .clk_16m (clk_16m),
            .rst_16m (rst_16m),
            .async_i (bus.dom_rst_req[gi]),
            .trig_o  (dom_trig[gi])
        );
    end

    always_comb begin
        dom_low = '0;
        for (int i = 0; i < N_DOM; i++) begin
            dom_low[i] = (dcnt_q[i] != '0);
        end
    end

    assign rst_n_d = rel_q & ~dom_low & ~bus.sleep_hold;
    assign busy_d  = (state_q != S_RUN);

    // rel_q marks domains released by the sequence; output regs add one stage
    always_ff @(posedge clk_16m) begin
        if (rst_16m) begin
            state_q <= S_HOLD;
            cnt_q   <= '0;
            idx_q   <= '0;
            rel_q   <= '0;
            rst_n_q <= '0;
            busy_q  <= 1'b1;
            for (int i = 0; i < N_DOM; i++) dcnt_q[i] <= '0;
        end else begin
            rst_n_q <= rst_n_d;
            busy_q  <= busy_d;
            if (sys_trig) begin
                state_q <= S_HOLD;
                cnt_q   <= '0;
                idx_q   <= '0;
                rel_q   <= '0;
                for (int i = 0; i < N_DOM; i++) dcnt_q[i] <= '0;
            end else begin
                for (int i = 0; i < N_DOM; i++) begin
                    if (dom_trig[i] && rel_q[i]) begin
                        dcnt_q[i] <= CNT_W'(HOLD);
                    end else if (dom_low[i]) begin
                        dcnt_q[i] <= dcnt_q[i] - CNT_W'(1);
                    end
                end
                case (state_q)
                    S_HOLD: begin
                        if (cnt_q == C_HOLD_LAST) begin
                            rel_q   <= rel_q | N_DOM'(1);
                            cnt_q   <= '0;
                            idx_q   <= IDX_W'(1);
                            state_q <= (N_DOM == 1) ? S_RUN : S_REL;
                        end else begin
                            cnt_q <= cnt_q + CNT_W'(1);
                        end
                    end
                    S_REL: begin
                        if (cnt_q == C_STAG_LAST) begin
                            rel_q <= rel_q | (N_DOM'(1) << idx_q);
                            cnt_q <= '0;
                            idx_q <= idx_q + IDX_W'(1);
                            if (idx_q == C_IDX_LAST) state_q <= S_RUN;
                        end else begin
                            cnt_q <= cnt_q + CNT_W'(1);
                        end
                    end
                    S_RUN:   ;
                    default: state_q <= S_HOLD;
                endcase
            end
        end
    end

    assign bus.rst_n_out = bus.test_en ? {N_DOM{bus.test_rst_n}} : rst_n_q;
    assign bus.seq_busy  = bus.test_en ? 1'b0 : busy_q;

`ifdef PMU_RSTSEQ_CAUSE_EN
    logic [1:0] cause_q;

    always_ff @(posedge clk_16m) begin
        if (rst_16m) begin
            cause_q <= CAUSE_POR;
        end else if (sys_trig) begin
            cause_q <= CAUSE_SYS;
        end else if (|(dom_trig & rel_q)) begin
            cause_q <= CAUSE_DOM;
        end else if (bus.cause_clr) begin
            cause_q <= CAUSE_POR;
        end
    end

    assign bus.rst_cause = cause_q;
`else
    logic unused_cause_clr;
    assign unused_cause_clr = bus.cause_clr;
    assign bus.rst_cause    = CAUSE_POR;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pmu_rstseq.sv
`default_nettype none
// ============================================================================
// Module   : tb_pmu_rstseq
// Purpose  : Self-checking bench; reference model works from release schedules
// Revision : 1.0 - initial release
// ============================================================================
module tb_pmu_rstseq;
    import pmu_rstseq_pkg::*;

    localparam int N       = 4;
    localparam int HOLD    = 15;
    localparam int STAGGER = 4;
    localparam int SYNC    = 2;
`ifdef PMU_RSTSEQ_CAUSE_EN
    localparam bit CAUSE_EN = 1'b1;
`else
    localparam bit CAUSE_EN = 1'b0;
`endif

    logic clk_16m = 1'b0;
    logic rst_16m = 1'b1;

    pmu_rstseq_if #(.N_DOM(N)) bus ();

    pmu_rstseq #(
        .N_DOM(N), .CNT_W(5), .HOLD(HOLD), .STAGGER(STAGGER), .SYNC_STAGES(SYNC)
    ) dut (
        .clk_16m (clk_16m),
        .rst_16m (rst_16m),
        .bus     (bus)
    );

    always #5 clk_16m = ~clk_16m;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int seq_s  = 0;
    int dlow_end [N];
    logic [SYNC+1:0] sys_h;
    logic [SYNC+1:0] dom_h [N];
    logic [N-1:0]    exp_rst_n;
    logic            exp_busy;
    logic [1:0]      exp_cause;

    // Output edge at which domain i of the current sequence goes high
    function automatic int rel_at(input int i);
        return seq_s + HOLD + 1 + i * STAGGER;
    endfunction

    task automatic model_edge();
        logic sys_t;
        logic hon;
        cyc++;
        if (rst_16m) begin
            seq_s     = cyc;
            sys_h     = '0;
            exp_rst_n = '0;
            exp_busy  = 1'b1;
            exp_cause = CAUSE_POR;
            for (int i = 0; i < N; i++) begin
                dom_h[i]    = '0;
                dlow_end[i] = -1000;
            end
        end else begin
            sys_h = {sys_h[SYNC:0], bus.sys_rst_req};
            for (int i = 0; i < N; i++) dom_h[i] = {dom_h[i][SYNC:0], bus.dom_rst_req[i]};
            for (int i = 0; i < N; i++)
                exp_rst_n[i] = (cyc >= rel_at(i)) && (cyc > dlow_end[i]) && !bus.sleep_hold[i];
            exp_busy = (cyc < rel_at(N - 1));
            sys_t = sys_h[SYNC] & ~sys_h[SYNC+1];
            if (sys_t) begin
                seq_s = cyc;
                for (int i = 0; i < N; i++) dlow_end[i] = -1000;
                if (CAUSE_EN) exp_cause = CAUSE_SYS;
            end else begin
                hon = 1'b0;
                for (int i = 0; i < N; i++) begin
                    if (dom_h[i][SYNC] && !dom_h[i][SYNC+1] && cyc >= rel_at(i)) begin
                        dlow_end[i] = cyc + HOLD;
                        hon = 1'b1;
                    end
                end
                if (CAUSE_EN) begin
                    if (hon) exp_cause = CAUSE_DOM;
                    else if (bus.cause_clr) exp_cause = CAUSE_POR;
                end
            end
        end
    endtask

    task automatic step();
        @(posedge clk_16m);
        model_edge();
        @(negedge clk_16m);
    endtask

    task automatic test_reset();
        rst_16m = 1'b1;
        repeat (4) begin
            step();
            checks++;
            if (bus.rst_n_out !== 4'b0000 || bus.seq_busy !== 1'b1 || bus.rst_cause !== 2'b00) begin
                errors++;
                $display("FAIL reset rst_n_out %b busy %b cause %b required 0000/1/00",
                         bus.rst_n_out, bus.seq_busy, bus.rst_cause);
            end
        end
        rst_16m = 1'b0;
    endtask

    task automatic test_por();
        logic [N-1:0] spot;
        for (int k = 0; k < 30; k++) begin
            step();
            checks++;
            if (bus.rst_n_out !== exp_rst_n || bus.seq_busy !== exp_busy || bus.rst_cause !== exp_cause) begin
                errors++;
                $display("FAIL por_model c%0d rst_n_out %b/%b busy %b/%b cause %b/%b", cyc,
                         bus.rst_n_out, exp_rst_n, bus.seq_busy, exp_busy, bus.rst_cause, exp_cause);
            end
            if (k == 14 || k == 15 || k == 19 || k == 23 || k == 27) begin
                spot = (k == 14) ? 4'b0000 : (k == 15) ? 4'b0001 : (k == 19) ? 4'b0011 :
                       (k == 23) ? 4'b0111 : 4'b1111;
                checks++;
                if (bus.rst_n_out !== spot) begin
                    errors++;
                    $display("FAIL por_release k%0d rst_n_out %b required %b", k, bus.rst_n_out, spot);
                end
            end
            if (k == 26 || k == 27) begin
                checks++;
                if (bus.seq_busy !== (k == 26)) begin
                    errors++;
                    $display("FAIL por_busy k%0d seq_busy %b required %b", k, bus.seq_busy, (k == 26));
                end
            end
        end
    endtask

    task automatic test_sys_run();
        bus.sys_rst_req = 1'b1;
        step();
        bus.sys_rst_req = 1'b0;
        for (int k = 1; k <= 32; k++) begin
            step();
            checks++;
            if (bus.rst_n_out !== exp_rst_n || bus.seq_busy !== exp_busy || bus.rst_cause !== exp_cause) begin
                errors++;
                $display("FAIL sys_model c%0d rst_n_out %b/%b busy %b/%b cause %b/%b", cyc,
                         bus.rst_n_out, exp_rst_n, bus.seq_busy, exp_busy, bus.rst_cause, exp_cause);
            end
            if (k == 2 || k == 3) begin
                checks++;
                if (bus.rst_n_out !== ((k == 2) ? 4'b1111 : 4'b0000) ||
                    bus.rst_cause !== ((k == 3 && CAUSE_EN) ? 2'b01 : (k == 3) ? 2'b00 : bus.rst_cause)) begin
                    errors++;
                    $display("FAIL sys_latency k%0d rst_n_out %b cause %b", k, bus.rst_n_out, bus.rst_cause);
                end
            end
        end
    endtask

    task automatic test_sys_retrig();
        int n;
        bus.sys_rst_req = 1'b1;
        step();
        bus.sys_rst_req = 1'b0;
        n = 0;
        while (bus.rst_n_out !== 4'b0011 && n < 40) begin
            step();
            n++;
            checks++;
            if (bus.rst_n_out !== exp_rst_n || bus.seq_busy !== exp_busy) begin
                errors++;
                $display("FAIL retrig_wait c%0d rst_n_out %b/%b busy %b/%b", cyc,
                         bus.rst_n_out, exp_rst_n, bus.seq_busy, exp_busy);
            end
        end
        checks++;
        if (n >= 40) begin
            errors++;
            $display("FAIL retrig_timeout rst_n_out %b required 0011", bus.rst_n_out);
        end
        bus.sys_rst_req = 1'b1;
        step();
        bus.sys_rst_req = 1'b0;
        for (int k = 1; k <= 32; k++) begin
            step();
            checks++;
            if (bus.rst_n_out !== exp_rst_n || bus.seq_busy !== exp_busy || bus.rst_cause !== exp_cause) begin
                errors++;
                $display("FAIL retrig_model c%0d rst_n_out %b/%b busy %b/%b cause %b/%b", cyc,
                         bus.rst_n_out, exp_rst_n, bus.seq_busy, exp_busy, bus.rst_cause, exp_cause);
            end
            if (k == 3 || k == 17 || k == 18) begin
                checks++;
                if (bus.rst_n_out !== ((k == 18) ? 4'b0001 : 4'b0000)) begin
                    errors++;
                    $display("FAIL retrig_release k%0d rst_n_out %b required %b", k, bus.rst_n_out,
                             (k == 18) ? 4'b0001 : 4'b0000);
                end
            end
        end
    endtask

    task automatic test_dom();
        int  lowcnt;
        logic others_bad;
        lowcnt = 0;
        others_bad = 1'b0;
        bus.dom_rst_req = 4'b0100;
        for (int k = 0; k < 25; k++) begin
            if (k == 5) bus.dom_rst_req = 4'b0000;
            step();
            if (bus.rst_n_out[2] === 1'b0) lowcnt++;
            if ({bus.rst_n_out[3], bus.rst_n_out[1:0]} !== 3'b111) others_bad = 1'b1;
            checks++;
            if (bus.rst_n_out !== exp_rst_n || bus.rst_cause !== exp_cause) begin
                errors++;
                $display("FAIL dom_model c%0d rst_n_out %b/%b cause %b/%b", cyc,
                         bus.rst_n_out, exp_rst_n, bus.rst_cause, exp_cause);
            end
        end
        checks++;
        if (lowcnt !== HOLD || others_bad || bus.rst_cause !== (CAUSE_EN ? 2'b10 : 2'b00)) begin
            errors++;
            $display("FAIL dom_hold low_cycles %0d required %0d others_disturbed %b cause %b",
                     lowcnt, HOLD, others_bad, bus.rst_cause);
        end
        bus.dom_rst_req = 4'b1000;
        bus.sys_rst_req = 1'b1;
        step();
        bus.dom_rst_req = 4'b0000;
        bus.sys_rst_req = 1'b0;
        for (int k = 1; k <= 32; k++) begin
            step();
            checks++;
            if (bus.rst_n_out !== exp_rst_n || bus.seq_busy !== exp_busy || bus.rst_cause !== exp_cause) begin
                errors++;
                $display("FAIL dom_sys_model c%0d rst_n_out %b/%b busy %b/%b cause %b/%b", cyc,
                         bus.rst_n_out, exp_rst_n, bus.seq_busy, exp_busy, bus.rst_cause, exp_cause);
            end
            if (k == 3) begin
                checks++;
                if (bus.rst_n_out !== 4'b0000 || bus.rst_cause !== (CAUSE_EN ? 2'b01 : 2'b00)) begin
                    errors++;
                    $display("FAIL dom_sys_priority rst_n_out %b cause %b required 0000/%b",
                             bus.rst_n_out, bus.rst_cause, CAUSE_EN ? 2'b01 : 2'b00);
                end
            end
        end
    endtask

    task automatic test_sleep();
        bus.sleep_hold = 4'b0010;
        for (int k = 1; k <= 11; k++) begin
            if (k == 11) bus.sleep_hold = 4'b0000;
            step();
            checks++;
            if (bus.rst_n_out !== exp_rst_n ||
                bus.rst_n_out !== ((k == 11) ? 4'b1111 : 4'b1101)) begin
                errors++;
                $display("FAIL sleep k%0d rst_n_out %b model %b required %b", k, bus.rst_n_out,
                         exp_rst_n, (k == 11) ? 4'b1111 : 4'b1101);
            end
        end
    endtask

    task automatic test_mode();
        bus.test_en    = 1'b1;
        bus.test_rst_n = 1'b0;
        #1;
        checks++;
        if (bus.rst_n_out !== 4'b0000 || bus.seq_busy !== 1'b0) begin
            errors++;
            $display("FAIL test_mode_low rst_n_out %b busy %b required 0000/0", bus.rst_n_out, bus.seq_busy);
        end
        bus.test_rst_n = 1'b1;
        #1;
        checks++;
        if (bus.rst_n_out !== 4'b1111 || bus.seq_busy !== 1'b0) begin
            errors++;
            $display("FAIL test_mode_high rst_n_out %b busy %b required 1111/0", bus.rst_n_out, bus.seq_busy);
        end
        bus.sys_rst_req = 1'b1;
        for (int k = 0; k < 8; k++) begin
            step();
            bus.sys_rst_req = 1'b0;
            bus.test_rst_n  = 1'($urandom_range(0, 1));
            #1;
            checks++;
            if (bus.rst_n_out !== {N{bus.test_rst_n}} || bus.seq_busy !== 1'b0) begin
                errors++;
                $display("FAIL test_mode_follow k%0d rst_n_out %b busy %b test_rst_n %b",
                         k, bus.rst_n_out, bus.seq_busy, bus.test_rst_n);
            end
        end
        bus.test_en = 1'b0;
        #1;
        checks++;
        if (bus.rst_n_out !== exp_rst_n || bus.seq_busy !== exp_busy || bus.rst_cause !== exp_cause ||
            bus.rst_cause !== (CAUSE_EN ? 2'b01 : 2'b00)) begin
            errors++;
            $display("FAIL test_mode_exit rst_n_out %b/%b busy %b/%b cause %b/%b", bus.rst_n_out,
                     exp_rst_n, bus.seq_busy, exp_busy, bus.rst_cause, exp_cause);
        end
        bus.cause_clr = 1'b1;
        step();
        bus.cause_clr = 1'b0;
        checks++;
        if (bus.rst_cause !== 2'b00 || bus.rst_cause !== exp_cause) begin
            errors++;
            $display("FAIL cause_clr rst_cause %b required 00", bus.rst_cause);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 700; i++) begin
            if (i == 350) rst_16m = 1'b1;
            if (i == 353) rst_16m = 1'b0;
            bus.sys_rst_req = ($urandom_range(0, 119) == 0);
            for (int d = 0; d < N; d++) begin
                if ($urandom_range(0, 15) == 0) bus.dom_rst_req[d] = ~bus.dom_rst_req[d];
                if ($urandom_range(0, 39) == 0) bus.sleep_hold[d]  = ~bus.sleep_hold[d];
            end
            bus.cause_clr = ($urandom_range(0, 29) == 0);
            step();
            checks++;
            if (bus.rst_n_out !== exp_rst_n || bus.seq_busy !== exp_busy || bus.rst_cause !== exp_cause) begin
                errors++;
                $display("FAIL random c%0d rst_n_out %b/%b busy %b/%b cause %b/%b", cyc,
                         bus.rst_n_out, exp_rst_n, bus.seq_busy, exp_busy, bus.rst_cause, exp_cause);
            end
        end
    endtask

    initial begin
        bus.test_en     = 1'b0;
        bus.test_rst_n  = 1'b0;
        bus.sys_rst_req = 1'b0;
        bus.dom_rst_req = '0;
        bus.sleep_hold  = '0;
        bus.cause_clr   = 1'b0;
        test_reset();
        test_por();
        test_sys_run();
        test_sys_retrig();
        test_dom();
        test_sleep();
        test_mode();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog simulation did not complete");
        $fatal(1);
    end

endmodule
`default_nettype wire
